// File: rtl/axi4lite_sram_slave.sv
// axi4lite_sram_slave
//   AXI4-lite slave word memory with 2**ADDR_BITS 32-bit words. It is used as
//   on-chip program/data RAM and as the default bench memory for the core.
//   The write and read channels are independent. Writes support byte strobes.
//   Reads can insert READ_WAIT extra cycles to emulate a slow memory. Every
//   access completes as OKAY, so the bus carries no resp signals.
//
// Ports
//   clk, reset           single clock; synchronous active-high reset
//   mem_axi_aw*          write address channel (awprot is ignored)
//   mem_axi_w*           write data channel with byte strobes
//   mem_axi_b*           write response channel (no resp field)
//   mem_axi_ar*          read address channel (arprot is ignored)
//   mem_axi_r*           read data channel (no resp field)
//
// Word index = addr[ADDR_BITS+1:2]. Higher address bits alias onto the memory.
module axi4lite_sram_slave #(
   parameter int ADDR_BITS = 10,
   parameter int READ_WAIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,
   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,
   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,
   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,
   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata
);

   localparam int         DEPTH   = 1 << ADDR_BITS;
   localparam logic [3:0] LP_WAIT = 4'(READ_WAIT);

   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

   logic [31:0]          r_mem [DEPTH];

   // write channel state
   logic                 r_aw_full;
   logic [ADDR_BITS-1:0] r_aw_idx;
   logic                 r_w_full;
   logic [31:0]          r_w_data;
   logic [3:0]           r_w_strb;
   logic                 r_bvalid;
   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_commit;

   // read channel state
   rd_state_t            r_state;
   rd_state_t            w_state_nxt;
   logic [3:0]           r_cnt;
   logic [ADDR_BITS-1:0] r_ar_idx;
   logic [31:0]          r_rdata;
   logic                 w_fetch;

   // address bits outside the word index and the prot fields carry no meaning here
   logic                 w_unused;
   assign w_unused = ^{mem_axi_awaddr[31:ADDR_BITS+2], mem_axi_awaddr[1:0],
                       mem_axi_araddr[31:ADDR_BITS+2], mem_axi_araddr[1:0],
                       mem_axi_awprot, mem_axi_arprot};

   // ---------------- write path ----------------
   assign mem_axi_awready = !r_aw_full && !r_bvalid;
   assign mem_axi_wready  = !r_w_full  && !r_bvalid;
   assign mem_axi_bvalid  = r_bvalid;
   assign w_aw_hs  = mem_axi_awvalid && mem_axi_awready;
   assign w_w_hs   = mem_axi_wvalid  && mem_axi_wready;
   assign w_commit = r_aw_full && r_w_full && !r_bvalid;

   // A commit needs both flags set, and the readies are low in that case.
   // So a commit and a new handshake never fall on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_aw_full <= 1'b0;
         r_w_full  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= mem_axi_awaddr[ADDR_BITS+1:2];
         end
         if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_w_data <= mem_axi_wdata;
            r_w_strb <= mem_axi_wstrb;
         end
         if (w_commit) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_bvalid  <= 1'b1;
         end else if (r_bvalid && mem_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // The memory is not reset. A commit that coincides with reset is dropped.
   always_ff @(posedge clk) begin
      if (w_commit && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (r_w_strb[b]) r_mem[r_aw_idx][8*b +: 8] <= r_w_data[8*b +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   assign mem_axi_arready = (r_state == RD_IDLE);
   assign mem_axi_rvalid  = (r_state == RD_RESP);
   assign mem_axi_rdata   = r_rdata;

   always_comb begin
      w_state_nxt = r_state;
      w_fetch     = 1'b0;
      case (r_state)
         RD_IDLE: if (mem_axi_arvalid) w_state_nxt = RD_WAIT;
         RD_WAIT: if (r_cnt == 4'd0) begin
            w_fetch     = 1'b1;
            w_state_nxt = RD_RESP;
         end
         RD_RESP: if (mem_axi_rready) w_state_nxt = RD_IDLE;
         default: w_state_nxt = RD_IDLE;
      endcase
   end

   // The fetch uses a non-blocking read of r_mem. A write committing on the
   // same edge is therefore not seen, so the read returns the pre-write word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RD_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == RD_IDLE && mem_axi_arvalid) begin
            r_ar_idx <= mem_axi_araddr[ADDR_BITS+1:2];
            r_cnt    <= LP_WAIT;
         end else if (r_state == RD_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_fetch) r_rdata <= r_mem[r_ar_idx];
      end
   end

endmodule
